// File: rtl/main_memory_pkg.sv
// -----------------------------------------------------------------------------
// main_memory_pkg
// Shared definitions for the main memory / boot loader block:
//   - controller state encoding (LOAD, RELEASE, RUN)
//   - read-data source selector used by the registered read mux
//   - I/O window offsets and the processor rw encoding
// -----------------------------------------------------------------------------
package main_memory_pkg;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    // Which source drives rdata for the cycle after an access.
    typedef enum logic [1:0] {
        RSRC_ZERO = 2'd0,
        RSRC_IO   = 2'd1,
        RSRC_MEM  = 2'd2
    } rsrc_e;

    localparam logic [3:0] IO_OUT   = 4'd0;
    localparam logic [3:0] IO_IN    = 4'd1;
    localparam logic       RW_WRITE = 1'b1;

endpackage

// File: rtl/main_memory_mem_array.sv
// -----------------------------------------------------------------------------
// main_memory_mem_array
// Single-port synchronous RAM, 2**ADDR_W words of 16 bits. One write port and
// a registered read-before-write output, so it maps directly onto a vendor
// block RAM. Contents are never reset.
//   clk      in   clock
//   we_i     in   write enable
//   addr_i   in   word index
//   wdata_i  in   write data
//   rdata_o  out  registered read data (content before any same-edge write)
// -----------------------------------------------------------------------------
module main_memory_mem_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [15:0]       wdata_i,
    output logic [15:0]       rdata_o
);

    logic [15:0] mem_q [0:(1<<ADDR_W)-1];
    logic [15:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/main_memory.sv
// -----------------------------------------------------------------------------
// main_memory
// Word-addressed main memory with a boot loader and a 16-word I/O window.
// After reset it optionally fills the array from a word stream while holding
// the processor in reset, then releases it and serves processor accesses.
//   clk         in   clock
//   reset       in   synchronous active-low reset
//   addr        in   processor word address
//   wdata       in   processor write data
//   rw          in   1 = write, 0 = read
//   rdata       out  registered read data (1 cycle latency)
//   cpu_reset   out  active-low processor reset, released after loading
//   boot_en     in   sampled in reset: 1 = load first, 0 = run directly
//   load_valid  in   loader word valid
//   load_data   in   loader word
//   load_last   in   final loader word marker
//   load_ready  out  loader word accepted this cycle when valid
//   in_port     in   external input, read at IO_BASE+1
//   out_port    out  external output register, written at IO_BASE+0
//   load_ovf    out  sticky: loader stream ran past the last array word
// -----------------------------------------------------------------------------
module main_memory
    import main_memory_pkg::*;
#(
    parameter int          ADDR_W  = 10,
    parameter logic [15:0] IO_BASE = 16'hFFF0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        rw,
    output logic [15:0] rdata,
    output logic        cpu_reset,
    input  logic        boot_en,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    input  logic [15:0] in_port,
    output logic [15:0] out_port,
    output logic        load_ovf
);

    state_e            state_q,    state_d;
    rsrc_e             rsrc_q,     rsrc_d;
    logic [ADDR_W-1:0] ptr_q,      ptr_d;
    logic [15:0]       out_port_q, out_port_d;
    logic [15:0]       io_val_q,   io_val_d;
    logic              ovf_q,      ovf_d;
    logic              cpu_reset_q;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;

    logic              in_load;
    logic              xfer;
    logic              io_sel;
    logic [3:0]        io_off;
    logic              is_write;

    assign in_load  = (state_q == ST_LOAD);
    assign xfer     = load_valid && in_load;
    assign io_sel   = (addr[15:4] == IO_BASE[15:4]);
    assign io_off   = addr[3:0];
    assign is_write = (rw == RW_WRITE);

    always_comb begin
        state_d    = state_q;
        rsrc_d     = RSRC_ZERO;
        ptr_d      = ptr_q;
        out_port_d = out_port_q;
        io_val_d   = 16'h0000;
        ovf_d      = ovf_q;
        mem_we     = 1'b0;
        mem_addr   = addr[ADDR_W-1:0];
        mem_wdata  = wdata;

        case (state_q)
            ST_LOAD: begin
                // The loader owns the write port; processor traffic is ignored.
                mem_addr  = ptr_q;
                mem_wdata = load_data;
                if (xfer) begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_q + 1'b1;
                    if (load_last) begin
                        state_d = ST_RELEASE;
                    end else if (ptr_q == {ADDR_W{1'b1}}) begin
                        // Stream filled the whole array without a last marker.
                        ovf_d   = 1'b1;
                        state_d = ST_RELEASE;
                    end
                end
            end
            ST_RELEASE: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (io_sel) begin
                    rsrc_d = RSRC_IO;
                    case (io_off)
                        IO_OUT: begin
                            io_val_d = out_port_q;
                            if (is_write) begin
                                out_port_d = wdata;
                            end
                        end
                        IO_IN:   io_val_d = in_port;
                        default: io_val_d = 16'h0000;
                    endcase
                end else begin
                    rsrc_d = RSRC_MEM;
                    mem_we = is_write;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= boot_en ? ST_LOAD : ST_RUN;
            rsrc_q      <= RSRC_ZERO;
            ptr_q       <= '0;
            out_port_q  <= 16'h0000;
            io_val_q    <= 16'h0000;
            ovf_q       <= 1'b0;
            cpu_reset_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsrc_q      <= rsrc_d;
            ptr_q       <= ptr_d;
            out_port_q  <= out_port_d;
            io_val_q    <= io_val_d;
            ovf_q       <= ovf_d;
            // Registered so the processor leaves reset one cycle after RUN is
            // entered, with a glitch-free edge.
            cpu_reset_q <= (state_q == ST_RUN);
        end
    end

    // Writes are blocked while reset is held so the array stays untouched.
    main_memory_mem_array #(
        .ADDR_W (ADDR_W)
    ) u_mem_array (
        .clk     (clk),
        .we_i    (mem_we && reset),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    assign rdata      = (rsrc_q == RSRC_MEM) ? mem_rdata : io_val_q;
    assign cpu_reset  = cpu_reset_q;
    assign out_port   = out_port_q;
    assign load_ovf   = ovf_q;
    // Not offered while reset is held, even though the state is already LOAD.
    assign load_ready = in_load && reset;

endmodule

// File: tb/tb_main_memory.sv
module tb_main_memory;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        rw;
    logic        boot_en;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_last;
    logic [15:0] in_port;

    logic [15:0] rdata,   s_rdata;
    logic        cpu_reset, s_cpu_reset;
    logic        load_ready, s_load_ready;
    logic [15:0] out_port, s_out_port;
    logic        load_ovf, s_load_ovf;

    always #5 clk = ~clk;

    main_memory #(.ADDR_W(10), .IO_BASE(16'hFFF0)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .rw(rw),
        .rdata(rdata), .cpu_reset(cpu_reset), .boot_en(boot_en),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .in_port(in_port), .out_port(out_port),
        .load_ovf(load_ovf)
    );

    // Small instance for the array-overflow boundary; shares all inputs.
    main_memory #(.ADDR_W(2), .IO_BASE(16'hFFF0)) dut_small (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .rw(rw),
        .rdata(s_rdata), .cpu_reset(s_cpu_reset), .boot_en(boot_en),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(s_load_ready), .in_port(in_port), .out_port(s_out_port),
        .load_ovf(s_load_ovf)
    );

    int checks = 0;
    int errors = 0;

    // Reference model of the large instance.
    logic [15:0] mem_m [1024];
    bit          vld_m [1024];
    logic [15:0] out_m;
    int          ptr_m;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic boot);
        reset      = 1'b0;
        boot_en    = boot;
        load_valid = 1'b0;
        load_last  = 1'b0;
        rw         = 1'b0;
        addr       = 16'h0000;
        tick();
        tick();
        chk("rst_rdata", rdata, 16'h0000);
        chk("rst_out_port", out_port, 16'h0000);
        chk("rst_cpu_reset", {15'd0, cpu_reset}, 16'd0);
        chk("rst_load_ready", {15'd0, load_ready}, 16'd0);
        chk("rst_load_ovf", {15'd0, load_ovf}, 16'd0);
        chk("rst_small_load_ovf", {15'd0, s_load_ovf}, 16'd0);
        reset = 1'b1;
        out_m = 16'h0000;
        ptr_m = 0;
        $display("reset boot_en=%0d", boot);
    endtask

    task automatic load_word(input logic [15:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        #1;
        chk("load_ready", {15'd0, load_ready}, 16'd1);
        tick();
        mem_m[ptr_m] = d;
        vld_m[ptr_m] = 1'b1;
        ptr_m++;
        chk("load_rdata_zero", rdata, 16'h0000);
        load_valid = 1'b0;
        load_last  = 1'b0;
        $display("load word %h last=%0d", d, last);
    endtask

    // Called right after the edge that took the final loader word.
    task automatic release_seq();
        chk("release_load_ready", {15'd0, load_ready}, 16'd0);
        chk("release_cpu_reset", {15'd0, cpu_reset}, 16'd0);
        tick();
        chk("run_entry_cpu_reset", {15'd0, cpu_reset}, 16'd0);
        tick();
        chk("cpu_reset_rise", {15'd1, cpu_reset}, 16'hFFFF & {15'd1, 1'b1});
        chk("run_load_ready", {15'd0, load_ready}, 16'd0);
    endtask

    task automatic run_op(input logic w, input logic [15:0] a, input logic [15:0] d);
        logic [15:0] expv;
        bit          known;
        bit          io;
        rw    = w;
        addr  = a;
        wdata = d;
        io    = (a[15:4] == 12'hFFF);
        known = 1'b1;
        if (io) begin
            if (a[3:0] == 4'd0)      expv = out_m;
            else if (a[3:0] == 4'd1) expv = in_port;
            else                     expv = 16'h0000;
        end else begin
            expv  = mem_m[a[9:0]];
            known = vld_m[a[9:0]];
        end
        tick();
        if (known) chk("run_rdata", rdata, expv);
        if (w) begin
            if (io) begin
                if (a[3:0] == 4'd0) out_m = d;
            end else begin
                mem_m[a[9:0]] = d;
                vld_m[a[9:0]] = 1'b1;
            end
        end
        chk("run_out_port", out_port, out_m);
        rw = 1'b0;
        $display("%s addr=%h wdata=%h rdata=%h", w ? "write" : "read ", a, d, rdata);
    endtask

    function automatic logic [15:0] rand_addr();
        logic [15:0] a;
        case ($urandom_range(0, 3))
            0:       a = 16'($urandom_range(0, 31));
            1:       a = 16'(($urandom_range(0, 62) << 10) | $urandom_range(0, 31));
            2:       a = {12'hFFF, 4'($urandom_range(0, 15))};
            default: a = 16'($urandom);
        endcase
        return a;
    endfunction

    initial begin
        logic [15:0] wv [4];
        logic [15:0] va, vb;

        reset = 1'b0; boot_en = 1'b0; addr = '0; wdata = '0; rw = 1'b0;
        load_valid = 1'b0; load_data = '0; load_last = 1'b0; in_port = '0;
        out_m = '0; ptr_m = 0;
        for (int i = 0; i < 1024; i++) vld_m[i] = 1'b0;

        // Boot load of three words, then read them back.
        do_reset(1'b1);
        load_word(16'h1111, 1'b0);
        load_word(16'h2222, 1'b0);
        load_word(16'h3333, 1'b1);
        release_seq();
        run_op(1'b0, 16'h0000, 16'h0);
        run_op(1'b0, 16'h0001, 16'h0);
        run_op(1'b0, 16'h0002, 16'h0);

        // Directed RUN accesses: read-after-write, aliasing, I/O window.
        run_op(1'b1, 16'h0005, 16'hBEEF);
        run_op(1'b0, 16'h0005, 16'h0);
        run_op(1'b0, 16'h0405, 16'h0);
        run_op(1'b1, 16'h0002, 16'hC0DE);
        run_op(1'b1, 16'hFFF0, 16'h00A5);
        in_port = 16'h1234;
        run_op(1'b0, 16'hFFF1, 16'h0);
        run_op(1'b1, 16'hFFF1, 16'h5555);
        run_op(1'b0, 16'hFFF0, 16'h0);
        run_op(1'b1, 16'hFFF7, 16'h7777);
        run_op(1'b0, 16'hFFF7, 16'h0);
        run_op(1'b1, 16'h0003, 16'h5A5A);

        // Randomized RUN traffic against the model.
        for (int i = 0; i < 200; i++) begin
            in_port = 16'($urandom);
            run_op(1'($urandom_range(0, 1)), rand_addr(), 16'($urandom));
        end

        // Loader gap: valid 1,0,1 writes only addresses 0 and 1.
        do_reset(1'b1);
        va = 16'($urandom);
        vb = 16'($urandom);
        load_word(va, 1'b0);
        load_valid = 1'b0;
        load_data  = 16'hDEAD;
        #1;
        chk("gap_load_ready", {15'd0, load_ready}, 16'd1);
        tick();
        $display("load gap");
        load_word(vb, 1'b1);
        release_seq();
        run_op(1'b0, 16'h0000, 16'h0);
        run_op(1'b0, 16'h0001, 16'h0);
        run_op(1'b0, 16'h0002, 16'h0);
        run_op(1'b0, 16'h0003, 16'h0);
        run_op(1'b1, 16'hFFF0, 16'h3C3C);

        // Reset in the middle of a load.
        do_reset(1'b1);
        load_word(16'hAAA0, 1'b0);
        load_word(16'hAAA1, 1'b0);
        do_reset(1'b1);
        load_word(16'hBBB0, 1'b1);
        release_seq();
        run_op(1'b0, 16'h0000, 16'h0);
        run_op(1'b0, 16'h0001, 16'h0);
        chk("midload_word0", mem_m[0], 16'hBBB0);
        chk("midload_word1", mem_m[1], 16'hAAA1);

        // Overflow on the 4-word instance; the large one keeps loading.
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) begin
            wv[i] = 16'($urandom);
            chk("small_ovf_before", {15'd0, s_load_ovf}, 16'd0);
            load_word(wv[i], 1'b0);
        end
        chk("small_ovf_set", {15'd0, s_load_ovf}, 16'd1);
        chk("small_release_ready", {15'd0, s_load_ready}, 16'd0);
        chk("big_no_ovf", {15'd0, load_ovf}, 16'd0);
        chk("big_still_load", {15'd0, load_ready}, 16'd1);
        tick();
        chk("small_run_entry_cpu_reset", {15'd0, s_cpu_reset}, 16'd0);
        tick();
        chk("small_cpu_reset", {15'd0, s_cpu_reset}, 16'd1);
        for (int i = 0; i < 8; i++) begin
            rw   = 1'b0;
            addr = 16'(i);
            tick();
            chk("small_read", s_rdata, wv[i % 4]);
            chk("big_load_rdata_zero", rdata, 16'h0000);
            $display("small read addr=%h rdata=%h", addr, s_rdata);
        end
        chk("small_ovf_sticky", {15'd0, s_load_ovf}, 16'd1);

        // Reset without boot goes straight to RUN.
        do_reset(1'b0);
        tick();
        chk("noboot_cpu_reset", {15'd0, cpu_reset}, 16'd1);
        chk("noboot_load_ready", {15'd0, load_ready}, 16'd0);
        run_op(1'b0, 16'h0000, 16'h0);
        run_op(1'b0, 16'h0001, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
